lfsr_stream_scrambler: RTL
==========================

// Module: lfsr_stream_scrambler
// PURPOSE
//  Parametrised LFSR scrambler/descrambler for the streaming datapath. Each accepted beat
//  processes DATA_W bits, LSB first. Supports additive, self-synchronous scramble and
//  self-synchronous descramble modes. Seed can be loaded at runtime or on every frame
//  start. Sits between the framer and the line coder, and the mirror on the RX side.
// PARAMETERS
//  DATA_W     8          bits per beat (1..64)
//  LFSR_W     15         LFSR length (2..32)
//  POLY       15'h6000   tap mask; feedback = ^(state & POLY); default x^15+x^14+1
//  INIT_SEED  15'h4A80   seed applied at reset and on reseed-by-SOF
//  MODE       0          0=additive, 1=self-sync scramble, 2=self-sync descramble
//  SOF_RESEED 1          1: reload seed_reg into LFSR before processing an in_sof beat
// PORTS
//  clk        in   1       clock
//  rst        in   1       asynchronous, active-high reset
//  load       in   1       capture seed_in into seed_reg and the LFSR this cycle
//  seed_in    in   LFSR_W  runtime seed
//  bypass     in   1       1: data passes unmodified; LFSR still advances
//  in_valid   in   1       input beat valid
//  in_ready   out  1       block can accept a beat
//  in_data    in   DATA_W  input beat
//  in_sof     in   1       first beat of frame
//  in_eof     in   1       last beat of frame
//  out_valid  out  1       output beat valid
//  out_ready  in   1       downstream accepts
//  out_data   out  DATA_W  processed beat
//  out_sof    out  1       in_sof delayed with its beat
//  out_eof    out  1       in_eof delayed with its beat
// BEHAVIOUR
//  - Reset: LFSR=seed_reg=INIT_SEED; out_valid=0, out_data=0, out_sof=0, out_eof=0.
//  - Beat accepted when in_valid && in_ready. in_ready = !load && (!out_valid || out_ready).
//  - Latency: 1 cycle, single output register. Output holds stable while out_valid && !out_ready.
//  - Per bit i=0..DATA_W-1, with state s before the step: fb = ^(s & POLY).
//    MODE0: y=x^fb, s<={s[W-2:0],fb}. MODE1: y=x^fb, s<={s[W-2:0],y}.
//    MODE2: y=x^fb, s<={s[W-2:0],x}. bypass: y=x, with s updated as the mode requires.
//  - LFSR and the output register change only on an accepted beat, or on load/reseed.
//  - SOF_RESEED=1 and an accepted beat with in_sof: the beat is processed from seed_reg,
//    not from the current LFSR state.
//  - load: seed_reg and LFSR <= seed_in. in_ready=0 in that cycle, so load and an accept
//    never coincide. An already valid output beat is unaffected.
//  - An all-zero seed in MODE0 locks the LFSR at 0, so y=x. This is legal and is not flagged.
//  - rst mid-frame: the in-flight output beat is dropped, and the stream restarts from INIT_SEED.
//  - Bit ordering: bit 0 of in_data is the first bit on the wire.
// STRUCTURE
//  - Shared pkg scrambler_pkg: MODE_ADDITIVE/MODE_SS_SCR/MODE_SS_DESCR localparams, the
//    default POLY and INIT_SEED constants, and a function lfsr_step_n(state, data, poly, mode)
//    returning {next_state, data_out}.
//  - Sub-module lfsr_step_comb: combinational unrolled DATA_W-bit step, reused by the
//    CRC/PRBS checker. This top holds seed_reg, the LFSR, the handshake and the output register.
// TESTING  (DATA_W=8, POLY=15'h6000 unless noted)
//  - MODE0, load seed 15'h0001, send 0xA5 then 0x00 -> out 0xA5 then 0x60; LFSR=0x8060? No:
//    check the keystream only. The bench model computes the state.
//  - Round trip: MODE1 instance feeding a MODE2 instance, both seeded 15'h4A80, with 1000
//    random bytes -> descrambler output == original. Also start the descrambler from seed 0:
//    after 2 beats its output matches (self-sync).
//  - Backpressure: out_ready held 0 for 5 cycles with in_valid=1 -> in_ready=0, and out_data
//    stable. No beat lost or duplicated after release, checked by a scoreboard.
//  - SOF reseed: two frames of 4 beats of 0x00 -> identical output sequences for both frames.
//    With SOF_RESEED=0 -> sequences differ.
//  - load during valid input: load=1, in_valid=1 -> in_ready=0 that cycle, no beat consumed.
//    The next beat uses seed_in.
//  - Async rst mid-frame, asserted between clock edges -> out_valid=0 immediately. The first beat
//    after release is processed from INIT_SEED. bypass=1 -> out_data==in_data.

Source files
------------

// File: rtl/scrambler_pkg.sv
// Shared definitions for the LFSR scrambler family: mode encodings, default
// polynomial/seed and the generic multi-bit LFSR step used by all instances.
package scrambler_pkg;

    localparam int unsigned MAX_LFSR_W = 32;
    localparam int unsigned MAX_DATA_W = 64;

    localparam logic [1:0] MODE_ADDITIVE = 2'd0;
    localparam logic [1:0] MODE_SS_SCR   = 2'd1;
    localparam logic [1:0] MODE_SS_DESCR = 2'd2;

    // x^15 + x^14 + 1 and its customary non-zero start value
    localparam logic [14:0] DEFAULT_POLY      = 15'h6000;
    localparam logic [14:0] DEFAULT_INIT_SEED = 15'h4A80;

    typedef struct packed {
        logic [MAX_LFSR_W-1:0] state;
        logic [MAX_DATA_W-1:0] data;
    } step_res_t;

    // Processes data_w bits LSB first; state bits at or above lfsr_w stay zero.
    function automatic step_res_t lfsr_step_n(
        input logic [MAX_LFSR_W-1:0] state,
        input logic [MAX_DATA_W-1:0] data,
        input logic [MAX_LFSR_W-1:0] poly,
        input logic [1:0]            mode,
        input int unsigned           lfsr_w,
        input int unsigned           data_w
    );
        step_res_t             res;
        logic [MAX_LFSR_W-1:0] s;
        logic [MAX_LFSR_W-1:0] mask;
        logic                  fb;
        logic                  x;
        logic                  y;
        logic                  shift_in;

        mask     = (lfsr_w >= MAX_LFSR_W) ? '1 : ((MAX_LFSR_W'(1) << lfsr_w) - MAX_LFSR_W'(1));
        s        = state & mask;
        res.data = '0;
        for (int unsigned i = 0; i < MAX_DATA_W; i++) begin
            if (i < data_w) begin
                fb = ^(s & poly);
                x  = data[6'(i)];
                y  = x ^ fb;
                case (mode)
                    MODE_SS_SCR:   shift_in = y;
                    MODE_SS_DESCR: shift_in = x;
                    default:       shift_in = fb;
                endcase
                res.data[6'(i)] = y;
                s = {s[MAX_LFSR_W-2:0], shift_in} & mask;
            end
        end
        res.state = s;
        return res;
    endfunction

endpackage

// File: rtl/lfsr_step_comb.sv
// Combinational DATA_W-bit LFSR step (unrolled); shared with the CRC/PRBS checker.
module lfsr_step_comb
    import scrambler_pkg::*;
#(
    parameter int unsigned       DATA_W = 8,
    parameter int unsigned       LFSR_W = 15,
    parameter logic [LFSR_W-1:0] POLY   = LFSR_W'(DEFAULT_POLY),
    parameter logic [1:0]        MODE   = MODE_ADDITIVE
) (
    input  logic [LFSR_W-1:0] state_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              bypass_i,
    output logic [LFSR_W-1:0] state_o,
    output logic [DATA_W-1:0] data_o
);

    step_res_t res;
    logic      unused_res;

    always_comb begin
        res = lfsr_step_n(MAX_LFSR_W'(state_i), MAX_DATA_W'(data_i), MAX_LFSR_W'(POLY),
                          MODE, LFSR_W, DATA_W);
    end

    // Bypass only affects the data path; the state still follows the mode.
    assign state_o    = res.state[LFSR_W-1:0];
    assign data_o     = bypass_i ? data_i : res.data[DATA_W-1:0];
    assign unused_res = ^res;

endmodule

// File: rtl/lfsr_stream_scrambler.sv
// Streaming LFSR scrambler/descrambler with runtime seed load, per-frame reseed
// and a single registered output stage (1-cycle latency).
module lfsr_stream_scrambler
    import scrambler_pkg::*;
#(
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       LFSR_W     = 15,
    parameter logic [LFSR_W-1:0] POLY       = LFSR_W'(DEFAULT_POLY),
    parameter logic [LFSR_W-1:0] INIT_SEED  = LFSR_W'(DEFAULT_INIT_SEED),
    parameter logic [1:0]        MODE       = MODE_ADDITIVE,
    parameter bit                SOF_RESEED = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic              bypass,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    input  logic              in_eof,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof,
    output logic              out_eof
);

    logic [LFSR_W-1:0] seed_q, seed_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [LFSR_W-1:0] step_state_in;
    logic [LFSR_W-1:0] step_state_out;
    logic [DATA_W-1:0] step_data_out;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_sof_q, out_sof_d;
    logic              out_eof_q, out_eof_d;
    logic              accept;

    // A load cycle never accepts, so seed capture and stepping cannot collide.
    assign in_ready = !load && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    assign step_state_in = (SOF_RESEED && in_sof) ? seed_q : lfsr_q;

    lfsr_step_comb #(
        .DATA_W (DATA_W),
        .LFSR_W (LFSR_W),
        .POLY   (POLY),
        .MODE   (MODE)
    ) u_step (
        .state_i  (step_state_in),
        .data_i   (in_data),
        .bypass_i (bypass),
        .state_o  (step_state_out),
        .data_o   (step_data_out)
    );

    always_comb begin
        seed_d      = seed_q;
        lfsr_d      = lfsr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sof_d   = out_sof_q;
        out_eof_d   = out_eof_q;

        if (load) begin
            seed_d = seed_in;
            lfsr_d = seed_in;
        end

        if (accept) begin
            lfsr_d      = step_state_out;
            out_valid_d = 1'b1;
            out_data_d  = step_data_out;
            out_sof_d   = in_sof;
            out_eof_d   = in_eof;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seed_q      <= INIT_SEED;
            lfsr_q      <= INIT_SEED;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
        end else begin
            seed_q      <= seed_d;
            lfsr_q      <= lfsr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;

endmodule
